sum_lane_accumulator: RTL

- Upstream feeder of the AHB master's checksum write-back path.
- Consumes a stream of DATA_WIDTH-bit data words and accumulates them round-robin into eight lane sums (word i goes to lane i mod 8).
- Block length is selected by DLEN.
- Presents SUM1..SUM8 with an isSumReady flag that the AHB master samples; the flag holds until the master acknowledges.

---
 rtl/sum_lane_accumulator_if.sv | 30 +++
 rtl/sum_lane_accumulator.sv | 97 +++++++++
 2 files changed

// File: rtl/sum_lane_accumulator_if.sv
// Stream-in / sums-out bundle between the data feeder, the lane accumulator and the AHB master.
interface sum_lane_accumulator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_ready;
    logic                  sum_ack;
    logic                  isSumReady;
    logic [DATA_WIDTH-1:0] SUM1;
    logic [DATA_WIDTH-1:0] SUM2;
    logic [DATA_WIDTH-1:0] SUM3;
    logic [DATA_WIDTH-1:0] SUM4;
    logic [DATA_WIDTH-1:0] SUM5;
    logic [DATA_WIDTH-1:0] SUM6;
    logic [DATA_WIDTH-1:0] SUM7;
    logic [DATA_WIDTH-1:0] SUM8;

    modport master (
        output din_valid, din, sum_ack,
        input  din_ready, isSumReady,
        input  SUM1, SUM2, SUM3, SUM4, SUM5, SUM6, SUM7, SUM8
    );

    modport slave (
        input  din_valid, din, sum_ack,
        output din_ready, isSumReady,
        output SUM1, SUM2, SUM3, SUM4, SUM5, SUM6, SUM7, SUM8
    );
endinterface

// File: rtl/sum_lane_accumulator.sv
// Round-robin eight-lane checksum accumulator feeding the AHB write-back master.
// Define SUM_ONES_COMPLEMENT_EN for end-around-carry lane addition; default is modulo-2^W.
module sum_lane_accumulator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic       HCLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [1:0] DLEN,
    output logic       busy,
    sum_lane_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [5:0]            cnt;
    logic [5:0]            len_m1;
    logic [DATA_WIDTH-1:0] sum_q [8];
    logic                  take;
    logic                  last;

    function automatic logic [DATA_WIDTH-1:0] lane_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef SUM_ONES_COMPLEMENT_EN
        // End-around carry; a+b+1 never carries out again, so one fold suffices.
        return s[DATA_WIDTH-1:0] + {{(DATA_WIDTH-1){1'b0}}, s[DATA_WIDTH]};
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

    function automatic logic [5:0] decode_len_m1(input logic [1:0] code);
        case (code)
            2'b00:   return 6'd7;
            2'b01:   return 6'd15;
            2'b10:   return 6'd31;
            default: return 6'd63;
        endcase
    endfunction

    assign take = (state == ACCUM) && bus.din_valid;
    assign last = (cnt == len_m1);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (take && last) state_next = DONE;
            DONE:    if (bus.sum_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            len_m1 <= 6'd7;
            for (int i = 0; i < 8; i++) sum_q[i] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                len_m1 <= decode_len_m1(DLEN);
                cnt    <= 6'd0;
                for (int i = 0; i < 8; i++) sum_q[i] <= '0;
            end else if (take) begin
                sum_q[cnt[2:0]] <= lane_add(sum_q[cnt[2:0]], bus.din);
                // Hold at the final index so a 64-word block never wraps the counter.
                if (!last) cnt <= cnt + 6'd1;
            end
        end
    end

    assign bus.din_ready  = (state == ACCUM);
    assign bus.isSumReady = (state == DONE);
    assign busy           = (state != IDLE);

    assign bus.SUM1 = sum_q[0];
    assign bus.SUM2 = sum_q[1];
    assign bus.SUM3 = sum_q[2];
    assign bus.SUM4 = sum_q[3];
    assign bus.SUM5 = sum_q[4];
    assign bus.SUM6 = sum_q[5];
    assign bus.SUM7 = sum_q[6];
    assign bus.SUM8 = sum_q[7];

endmodule
